// File: rtl/mul_acc_pipe_pkg.sv
// Shared constants for the multiply-accumulate pipeline.
package mul_acc_pipe_pkg;

    // iAcc encoding: start a new sum or fold into the running one
    localparam logic ACC_LOAD = 1'b0;
    localparam logic ACC_ADD  = 1'b1;

    // Accumulator width: full product plus guard bits
    function automatic int acc_width(input int size, input int guard);
        return 2 * size + guard;
    endfunction

endpackage

// File: rtl/IMUL1_LOGIC.sv
// Combinational unsigned array multiplier: sum of shifted partial products.
module IMUL1_LOGIC #(
    parameter int SIZE = 16
) (
    input  logic [SIZE-1:0]   iA,
    input  logic [SIZE-1:0]   iB,
    output logic [2*SIZE-1:0] oProd
);

    logic [2*SIZE-1:0] a_ext;

    assign a_ext = {{SIZE{1'b0}}, iA};

    // One row per multiplier bit; each row is the multiplicand gated and shifted
    always_comb begin
        oProd = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (iB[i]) oProd = oProd + (a_ext << i);
        end
    end

endmodule

// File: rtl/mul_acc_pipe.sv
// Two-stage handshaked MAC: S1 registers operands, S2 multiplies and folds
// the product into a guarded accumulator presented over valid/ready.
module mul_acc_pipe
    import mul_acc_pipe_pkg::*;
#(
    parameter int SIZE  = 16,
    parameter int GUARD = 8,
    parameter int CNT_W = 8,
    localparam int ACC_W = acc_width(SIZE, GUARD)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iValid,
    output logic             oReady,
    input  logic [SIZE-1:0]  iA,
    input  logic [SIZE-1:0]  iB,
    input  logic             iAcc,
    input  logic             iClear,
    output logic             oValid,
    input  logic             iReady,
    output logic [ACC_W-1:0] oResult,
    output logic             oOverflow,
    output logic [CNT_W-1:0] oCount
);

    // S1 operand stage
    logic             s1_vld_q;
    logic [SIZE-1:0]  a_q, b_q;
    logic             mode_q;

    // S2 accumulator / output stage
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vld_q, vld_d;

    logic             stall, accept, fire;
    logic [2*SIZE-1:0] prod;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] base_acc;
    logic             base_ovf;
    logic [CNT_W-1:0] base_cnt;
    logic [ACC_W:0]   sum;

    // Whole pipe freezes only while a result sits unconsumed
    assign stall  = vld_q & ~iReady;
    assign oReady = ~stall;
    assign accept = iValid & ~stall;
    assign fire   = s1_vld_q & ~stall;

    IMUL1_LOGIC #(.SIZE(SIZE)) u_mul (
        .iA    (a_q),
        .iB    (b_q),
        .oProd (prod)
    );

    assign prod_ext = ACC_W'(prod);

    // S1 capture; holds operands under stall, drops valid when nothing arrives
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            s1_vld_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= ACC_LOAD;
        end else if (!stall) begin
            s1_vld_q <= accept;
            if (accept) begin
                a_q    <= iA;
                b_q    <= iB;
                mode_q <= iAcc;
            end
        end
    end

    // Accumulator next state; a same-edge clear zeroes the base the fold starts from
    always_comb begin
        base_acc = iClear ? '0 : acc_q;
        base_ovf = iClear ? 1'b0 : ovf_q;
        base_cnt = iClear ? '0 : cnt_q;
        sum      = {1'b0, base_acc} + {1'b0, prod_ext};
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        vld_d    = vld_q;
        if (fire) begin
            vld_d = 1'b1;
            if (mode_q == ACC_LOAD) begin
                acc_d = prod_ext;
                ovf_d = 1'b0;
                cnt_d = CNT_W'(1);
            end else begin
                acc_d = sum[ACC_W-1:0];
                ovf_d = base_ovf | sum[ACC_W];
                cnt_d = (&base_cnt) ? base_cnt : base_cnt + CNT_W'(1);
            end
        end else begin
            if (iClear) begin
                acc_d = '0;
                ovf_d = 1'b0;
                cnt_d = '0;
            end
            if (vld_q & iReady) vld_d = 1'b0;
        end
    end

    // S2 / output registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
            vld_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
            vld_q <= vld_d;
        end
    end

    assign oValid    = vld_q;
    assign oResult   = acc_q;
    assign oOverflow = ovf_q;
    assign oCount    = cnt_q;

endmodule

// File: tb/tb_mul_acc_pipe.sv
// Bench: a wide (GUARD=8) and a narrow (GUARD=0) instance share stimulus and
// are compared each cycle against a transaction-level accumulator model.
module tb_mul_acc_pipe;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iValid, iAcc, iClear, iReady;
    logic [15:0] iA, iB;

    logic        w_rdy, w_vld, w_ovf, n_rdy, n_vld, n_ovf;
    logic [39:0] w_res;
    logic [31:0] n_res;
    logic [7:0]  w_cnt, n_cnt;

    int ncmp = 0;
    int nfail = 0;

    always #5 Clock = ~Clock;

    mul_acc_pipe u_w (
        .Clock(Clock), .Reset(Reset), .iValid(iValid), .oReady(w_rdy),
        .iA(iA), .iB(iB), .iAcc(iAcc), .iClear(iClear),
        .oValid(w_vld), .iReady(iReady), .oResult(w_res),
        .oOverflow(w_ovf), .oCount(w_cnt)
    );

    mul_acc_pipe #(.SIZE(16), .GUARD(0), .CNT_W(8)) u_n (
        .Clock(Clock), .Reset(Reset), .iValid(iValid), .oReady(n_rdy),
        .iA(iA), .iB(iB), .iAcc(iAcc), .iClear(iClear),
        .oValid(n_vld), .iReady(iReady), .oResult(n_res),
        .oOverflow(n_ovf), .oCount(n_cnt)
    );

    // Reference model: one operand slot, one running sum per accumulator width
    typedef struct { longint unsigned a, b; bit acc; } beat_t;
    beat_t           m_s1[$];
    bit              m_valid;
    longint unsigned m_acc[2];
    bit              m_ovf[2];
    int              m_cnt[2];
    int              W[2] = '{40, 32};
    bit              last_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1.delete();
        m_valid = 0;
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0; m_ovf[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic model_step();
        bit stall, fired;
        beat_t bt;
        longint unsigned prod, base, s, lim;
        bit bo;
        int bc;
        stall = m_valid && !iReady;
        fired = 0;
        if (!stall && m_s1.size() != 0) begin
            bt = m_s1.pop_front();
            fired = 1;
            prod = bt.a * bt.b;
            for (int k = 0; k < 2; k++) begin
                lim = 64'd1 << W[k];
                if (!bt.acc) begin
                    m_acc[k] = prod; m_ovf[k] = 0; m_cnt[k] = 1;
                end else begin
                    base = iClear ? 0 : m_acc[k];
                    bo   = iClear ? 0 : m_ovf[k];
                    bc   = iClear ? 0 : m_cnt[k];
                    s    = base + prod;
                    m_acc[k] = s % lim;
                    m_ovf[k] = bo | (s >= lim);
                    m_cnt[k] = (bc >= 255) ? 255 : bc + 1;
                end
            end
        end else if (iClear) begin
            for (int k = 0; k < 2; k++) begin
                m_acc[k] = 0; m_ovf[k] = 0; m_cnt[k] = 0;
            end
        end
        if (fired) m_valid = 1;
        else if (m_valid && iReady) m_valid = 0;
        if (!stall && iValid) begin
            bt.a = 64'(iA); bt.b = 64'(iB); bt.acc = iAcc;
            m_s1.push_back(bt);
        end
    endtask

    // One clock: check ready, advance model, take the edge, check outputs
    task automatic tick();
        #1;
        last_ready = w_rdy;
        chk("w_ready", 64'(w_rdy), 64'(!(m_valid && !iReady)));
        chk("n_ready", 64'(n_rdy), 64'(!(m_valid && !iReady)));
        model_step();
        @(posedge Clock);
        #1;
        chk("w_valid", 64'(w_vld), 64'(m_valid));
        chk("w_result", 64'(w_res), m_acc[0]);
        chk("w_ovf", 64'(w_ovf), 64'(m_ovf[0]));
        chk("w_count", 64'(w_cnt), 64'(m_cnt[0]));
        chk("n_valid", 64'(n_vld), 64'(m_valid));
        chk("n_result", 64'(n_res), m_acc[1]);
        chk("n_ovf", 64'(n_ovf), 64'(m_ovf[1]));
        chk("n_count", 64'(n_cnt), 64'(m_cnt[1]));
    endtask

    task automatic beat(input logic v, input logic [15:0] a, input logic [15:0] b, input logic acc);
        iValid = v; iA = a; iB = b; iAcc = acc;
    endtask

    int          acc_n;
    logic [39:0] got[$];

    initial begin
        Reset = 0; iClear = 0; iReady = 1;
        beat(0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge Clock);
        #3;
        Reset = 1;
        #1;
        chk("rst_valid", 64'(w_vld), 0);
        chk("rst_result", 64'(w_res), 0);
        chk("rst_ovf", 64'(w_ovf), 0);
        chk("rst_count", 64'(w_cnt), 0);
        chk("rst_ready", 64'(w_rdy), 1);
        tick();

        // single load 3*5
        beat(1, 3, 5, 0); tick();
        beat(0, 0, 0, 0); tick();
        chk("load15_valid", 64'(w_vld), 1);
        chk("load15_result", 64'(w_res), 15);
        chk("load15_count", 64'(w_cnt), 1);
        tick();
        chk("load15_drop", 64'(w_vld), 0);

        // back-to-back 0xFFFF chain; narrow instance overflows on 2nd fold
        beat(1, 16'hFFFF, 16'hFFFF, 0); tick();
        beat(1, 16'hFFFF, 16'hFFFF, 1); tick();
        chk("b2b_r1", 64'(w_res), 64'hFFFE0001);
        chk("b2b_c1", 64'(w_cnt), 1);
        tick();
        chk("b2b_r2", 64'(w_res), 64'h1FFFC0002);
        chk("b2b_c2", 64'(w_cnt), 2);
        chk("ovf_narrow_r", 64'(n_res), 64'hFFFC0002);
        chk("ovf_narrow_f", 64'(n_ovf), 1);
        tick();
        chk("b2b_r3", 64'(w_res), 64'h2FFFA0003);
        beat(0, 0, 0, 0); tick();
        chk("b2b_r4", 64'(w_res), 64'h3FFF80004);
        chk("b2b_c4", 64'(w_cnt), 4);
        chk("b2b_v4", 64'(w_vld), 1);
        beat(1, 2, 2, 0); tick();
        beat(0, 0, 0, 0); tick();
        chk("ovf_reload_r", 64'(n_res), 4);
        chk("ovf_reload_f", 64'(n_ovf), 0);
        tick();

        // backpressure: three loads 1,4,9 against a stalled consumer
        iReady = 0;
        acc_n = 1;
        beat(1, 1, 1, 0);
        for (int c = 0; c < 6; c++) begin
            tick();
            if (last_ready && acc_n <= 3) begin
                acc_n++;
                if (acc_n <= 3) beat(1, 16'(acc_n), 16'(acc_n), 0);
                else beat(0, 0, 0, 0);
            end
        end
        chk("bp_ready_low", 64'(w_rdy), 0);
        chk("bp_hold_result", 64'(w_res), 1);
        chk("bp_in_flight", 64'(acc_n - 1), 2);
        iReady = 1;
        for (int c = 0; c < 10 && got.size() < 3; c++) begin
            #1;
            if (w_vld && iReady) got.push_back(w_res);
            tick();
            if (last_ready && acc_n <= 3) begin
                acc_n++;
                if (acc_n <= 3) beat(1, 16'(acc_n), 16'(acc_n), 0);
                else beat(0, 0, 0, 0);
            end
        end
        chk("bp_count", 64'(got.size()), 3);
        if (got.size() == 3) begin
            chk("bp_res0", 64'(got[0]), 1);
            chk("bp_res1", 64'(got[1]), 4);
            chk("bp_res2", 64'(got[2]), 9);
        end
        beat(0, 0, 0, 0);
        repeat (2) tick();

        // clear alone while a result is held
        beat(1, 2, 3, 0); tick();
        beat(1, 4, 5, 1); tick();
        beat(0, 0, 0, 0); tick();
        chk("clr_pre_r", 64'(w_res), 26);
        chk("clr_pre_c", 64'(w_cnt), 2);
        iReady = 0;
        iClear = 1; tick();
        iClear = 0;
        chk("clr_r", 64'(w_res), 0);
        chk("clr_c", 64'(w_cnt), 0);
        chk("clr_v", 64'(w_vld), 1);
        iReady = 1; tick();

        // clear on the same edge an accumulate of 7*6 completes
        beat(1, 1, 1, 0); tick();
        beat(1, 7, 6, 1); tick();
        beat(0, 0, 0, 0); iClear = 1; tick();
        iClear = 0;
        chk("clr_fold_r", 64'(w_res), 42);
        chk("clr_fold_c", 64'(w_cnt), 1);
        tick();

        // count saturation
        beat(1, 1, 1, 0); tick();
        iAcc = 1;
        repeat (259) tick();
        beat(0, 0, 0, 0); tick();
        chk("sat_count", 64'(w_cnt), 255);
        chk("sat_result", 64'(w_res), 260);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            beat(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 1'($urandom));
            iClear = ($urandom_range(0, 15) == 0);
            iReady = ($urandom_range(0, 3) != 0);
            tick();
        end
        beat(0, 0, 0, 0); iClear = 0; iReady = 1;

        // reset mid-stream
        beat(1, 9, 9, 0); tick();
        beat(1, 5, 5, 1); tick();
        #1 Reset = 0;
        #1;
        model_reset();
        chk("mrst_valid", 64'(w_vld), 0);
        chk("mrst_result", 64'(w_res), 0);
        chk("mrst_count", 64'(w_cnt), 0);
        chk("mrst_ovf", 64'(w_ovf), 0);
        beat(0, 0, 0, 0);
        #2 Reset = 1;
        repeat (4) tick();
        chk("mrst_no_stray", 64'(w_vld), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/mul_acc_pipe.md
Name: mul_acc_pipe

Overview:
- Pipelined, handshaked multiply-accumulate stage built around the team's combinational unsigned array multiplier.
- Registers operands and feeds them to the multiplier. Consumes the 2*SIZE-bit product and folds it into a guarded accumulator.
- Presents the accumulator to a downstream consumer over valid/ready.
- Sits between the register-file/datapath issue logic and the writeback path.

Parameters:
- SIZE, 16, operand width in bits; must be at least 2.
- GUARD, 8, extra accumulator bits above 2*SIZE; 0 is legal.
- CNT_W, 8, width of the beat counter.
- Derived: ACC_W = 2*SIZE+GUARD.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- iValid  input  1  operand beat valid.
- oReady  output  1  block accepts a beat this cycle.
- iA  input  SIZE  unsigned multiplicand.
- iB  input  SIZE  unsigned multiplier.
- iAcc  input  1  1 = accumulate product into acc; 0 = load product (start new sum).
- iClear  input  1  synchronous clear of accumulator, flag and counter.
- oValid  output  1  oResult holds a new, unconsumed result.
- iReady  input  1  downstream accepts the result.
- oResult  output  ACC_W  accumulator value.
- oOverflow  output  1  sticky carry-out of the accumulator since the last load/clear.
- oCount  output  CNT_W  beats folded since the last load/clear; saturates at all-ones.

Behaviour:
- Reset (Reset=0, asynchronous): S1 valid=0, oValid=0, oResult=0, oOverflow=0, oCount=0, operand registers=0. oReady=1 once Reset deasserts.
- stall = oValid & ~iReady. oReady = ~stall (combinational). All stages advance together when ~stall.
- A beat is accepted on an edge where iValid & oReady.
- S1 (edge N): captures iA, iB, iAcc; S1 valid <= 1. If no beat is accepted and ~stall, S1 valid <= 0.
- S2 (edge N+1, S1 valid & ~stall):
  - prod = S1.A*S1.B, zero-extended to ACC_W.
  - Load: acc <= prod, oOverflow <= 0, oCount <= 1.
  - Accumulate: acc <= (acc+prod) mod 2^ACC_W; oOverflow <= oOverflow | carry; oCount <= sat(oCount+1).
  - oValid <= 1.
- Latency: result visible the cycle after edge N+1.
- Throughput: one beat per cycle without backpressure; back-to-back accumulates chain with no bubble.
- Output handshake: oValid cleared on an edge where oValid & iReady and no new S2 result. If a new S2 result lands on the same edge, oValid stays 1 with the new value.
- Under stall: oResult, oOverflow, oCount and S1 are held stable. At most 2 beats are in flight; none are lost or duplicated.
- iClear, ignoring stall:
  - If no S2 result on the same edge: acc, oOverflow and oCount <= 0; oValid unchanged.
  - If an S2 result completes on the same edge (only possible when ~stall): accumulation is computed with acc=0, flag=0, count=0, so the result equals prod with count 1.
  - iClear does not affect S1.
- Reset mid-operation: in-flight beats discarded; no result emitted after release.
- iA/iB/iAcc are ignored when iValid=0 or oReady=0.

Decomposition:
- Shared package holds ACC_W derivation and the mode constants (ACC_LOAD=0, ACC_ADD=1).
- One natural sub-module: the existing combinational multiplier IMUL1_LOGIC #(SIZE), instantiated between the S1 registers and the accumulator adder.
- Keep the accumulator adder inline.

Test Plan:
- Reset held then released -> oValid=0, oResult=0, oOverflow=0, oCount=0, oReady=1. Assert Reset mid-stream -> all outputs 0 asynchronously, no stray oValid afterwards.
- Single load, iA=3, iB=5, iAcc=0, iReady=1 -> two edges later oValid=1 for 1 cycle, oResult=15, oCount=1, oOverflow=0.
- Back-to-back beats iA=iB=0xFFFF (load, then 3x accumulate), iReady=1 -> consecutive cycles:
  - 0xFFFE0001 count 1
  - 0x1FFFC0002 count 2
  - 0x2FFFA0003 count 3
  - 0x3FFF80004 count 4
- Overflow, GUARD=0 (ACC_W=32): load 0xFFFF*0xFFFF then accumulate the same -> oResult=0xFFFC0002, oOverflow=1. Next load 2*2 -> oResult=4, oOverflow=0.
- Backpressure: iReady=0, three load beats 1*1, 2*2, 3*3 offered continuously:
  - oReady drops once oValid=1; oResult stays at 1 until released.
  - Then iReady=1 -> results 1, 4, 9 in order, none dropped.
- iClear alone mid-sum -> oResult=0, oCount=0, oOverflow=0, oValid unchanged. iClear on the same edge an accumulate beat 7*6 completes -> oResult=42, oCount=1.
